// File: rtl/if_id_skid_if.sv
// Fetch-to-decode channel bundle for the IF/ID skid stage.
// Carries the upstream beat, the downstream beat, flush and stall debug.
interface if_id_skid_if #(
    parameter int INST_W = 32,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] in_inst;
    logic [PC_W-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [PC_W-1:0]   out_pc;
    logic              flush;
    logic [CNT_W-1:0]  stall_cnt;
    logic              stall_clr;

    modport master (
        output in_valid, in_inst, in_pc,
        output out_ready, flush, stall_clr,
        input  in_ready, out_valid, out_inst, out_pc, stall_cnt
    );

    modport slave (
        input  in_valid, in_inst, in_pc,
        input  out_ready, flush, stall_clr,
        output in_ready, out_valid, out_inst, out_pc, stall_cnt
    );
endinterface

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage with a 2-entry skid buffer, flush and a
// saturating stall counter; in_ready is registered to cut the stall path.
module if_id_skid_stage #(
    parameter int                INST_W   = 32,
    parameter int                PC_W     = 32,
    parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0013,
    parameter int                CNT_W    = 16
) (
    input  logic          clk,
    input  logic          rst,
    if_id_skid_if.slave   bus
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t            state, state_nxt;
    logic              in_ready_q;
    logic [INST_W-1:0] main_inst, skid_inst;
    logic [PC_W-1:0]   main_pc, skid_pc;
    logic [CNT_W-1:0]  cnt;

    logic accept, deliver, main_valid;
    logic ld_main_in, ld_main_skid, ld_skid;

    assign main_valid = (state != EMPTY);
    assign accept     = bus.in_valid & in_ready_q;
    assign deliver    = main_valid & bus.out_ready;

    always_comb begin
        state_nxt    = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (bus.flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt  = ONE;
                        ld_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        ld_main_in = 1'b1;
                    end else if (accept) begin
                        state_nxt = TWO;
                        ld_skid   = 1'b1;
                    end else if (deliver) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (deliver) begin
                        state_nxt    = ONE;
                        ld_main_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != TWO);
        end
    end

    // Data only moves on accept or promotion, so X never reaches valids.
    always_ff @(posedge clk) begin
        if (ld_main_in) begin
            main_inst <= bus.in_inst;
            main_pc   <= bus.in_pc;
        end else if (ld_main_skid) begin
            main_inst <= skid_inst;
            main_pc   <= skid_pc;
        end
        if (ld_skid) begin
            skid_inst <= bus.in_inst;
            skid_pc   <= bus.in_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (bus.stall_clr) begin
            cnt <= '0;
        end else if (main_valid && !bus.out_ready && !bus.flush
                     && cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = main_valid;
    assign bus.out_inst  = main_valid ? main_inst : NOP_INST;
    assign bus.out_pc    = main_valid ? main_pc : '0;
    assign bus.stall_cnt = cnt;
endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed bench for if_id_skid_stage: queue-based model checked every
// cycle plus literal expectations from the test plan.
module tb_if_id_skid_stage;
    localparam int INST_W = 32;
    localparam int PC_W   = 32;
    localparam int CNT_W  = 3;
    localparam logic [31:0] NOP = 32'h13;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } beat_t;

    logic clk = 0;
    logic rst = 0;
    int   errors = 0;
    int   checks = 0;

    if_id_skid_if #(.INST_W(INST_W), .PC_W(PC_W), .CNT_W(CNT_W)) bus();

    if_id_skid_stage #(
        .INST_W(INST_W), .PC_W(PC_W), .NOP_INST(NOP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    beat_t q[$];
    int    m_cnt;
    int    cnt_max = (1 << CNT_W) - 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: an ordered FIFO of at most two held beats.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_cnt = 0;
        end else begin
            bit acc, dlv, held;
            held = q.size() > 0;
            acc  = bus.in_valid && q.size() < 2;
            dlv  = held && bus.out_ready;
            if (bus.stall_clr) m_cnt = 0;
            else if (held && !bus.out_ready && !bus.flush && m_cnt < cnt_max)
                m_cnt++;
            if (bus.flush) begin
                q.delete();
            end else begin
                if (dlv) void'(q.pop_front());
                if (acc) q.push_back('{inst: bus.in_inst, pc: bus.in_pc});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_out_valid", bus.out_valid, q.size() > 0);
            chk("m_in_ready", bus.in_ready, q.size() < 2);
            chk("m_out_inst", bus.out_inst, q.size() > 0 ? q[0].inst : NOP);
            chk("m_out_pc", bus.out_pc, q.size() > 0 ? q[0].pc : 32'h0);
            chk("m_stall_cnt", bus.stall_cnt, m_cnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] pc, input logic [31:0] inst);
        bus.in_valid = 1;
        bus.in_pc    = pc;
        bus.in_inst  = inst;
    endtask

    initial begin
        bus.in_valid  = 0;
        bus.in_inst   = 0;
        bus.in_pc     = 0;
        bus.out_ready = 0;
        bus.flush     = 0;
        bus.stall_clr = 0;
        #1 rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_stall_cnt", bus.stall_cnt, 0);

        // idle: NOP on output
        repeat (3) step();
        chk("idle_inst", bus.out_inst, 32'h13);
        chk("idle_pc", bus.out_pc, 0);

        // streaming
        bus.out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            beat(4 * (i + 1), 32'hA0 + i);
            step();
            chk("stream_pc", bus.out_pc, 4 * (i + 1));
            chk("stream_inst", bus.out_inst, 32'hA0 + i);
            chk("stream_rdy", bus.in_ready, 1);
        end
        bus.in_valid = 0;
        step();
        chk("stream_drain", bus.out_valid, 0);
        chk("stream_cnt", bus.stall_cnt, 0);

        // backpressure
        bus.out_ready = 0;
        beat(4, 32'hB0);
        step();
        beat(8, 32'hB1);
        step();
        bus.in_valid = 0;
        chk("bp_two_rdy", bus.in_ready, 0);
        repeat (3) step();
        chk("bp_hold_pc", bus.out_pc, 4);
        chk("bp_cnt4", bus.stall_cnt, 4);
        bus.out_ready = 1;
        step();
        chk("bp_pc8", bus.out_pc, 8);
        chk("bp_rdy_back", bus.in_ready, 1);
        step();
        chk("bp_empty", bus.out_valid, 0);

        // flush in TWO with an incoming beat
        bus.stall_clr = 1;
        step();
        bus.stall_clr = 0;
        bus.out_ready = 0;
        beat(24, 32'hC0);
        step();
        beat(28, 32'hC1);
        step();
        chk("fl_two", bus.in_ready, 0);
        beat(32, 32'hC2);
        bus.flush = 1;
        step();
        bus.flush    = 0;
        bus.in_valid = 0;
        chk("fl_valid", bus.out_valid, 0);
        chk("fl_inst", bus.out_inst, 32'h13);
        chk("fl_rdy", bus.in_ready, 1);
        step();
        chk("fl_no_ghost", bus.out_valid, 0);

        // flush in ONE while a beat is accepted
        beat(36, 32'hC3);
        step();
        beat(40, 32'hC4);
        bus.flush = 1;
        step();
        bus.flush    = 0;
        bus.in_valid = 0;
        chk("fl1_valid", bus.out_valid, 0);
        step();
        chk("fl1_no_ghost", bus.out_valid, 0);

        // counter saturation and clear
        bus.stall_clr = 1;
        step();
        bus.stall_clr = 0;
        beat(44, 32'hD0);
        step();
        bus.in_valid = 0;
        repeat (10) step();
        chk("sat_cnt", bus.stall_cnt, 7);
        step();
        chk("sat_hold", bus.stall_cnt, 7);
        bus.stall_clr = 1;
        step();
        bus.stall_clr = 0;
        chk("clr_cnt", bus.stall_cnt, 0);

        // async reset while in TWO
        beat(48, 32'hD1);
        step();
        bus.in_valid = 0;
        chk("ar_two", bus.in_ready, 0);
        #2 rst = 1;
        #1;
        chk("ar_valid", bus.out_valid, 0);
        chk("ar_rdy", bus.in_ready, 1);
        chk("ar_inst", bus.out_inst, 32'h13);
        chk("ar_cnt", bus.stall_cnt, 0);
        @(posedge clk);
        #1 rst = 0;
        bus.out_ready = 1;
        beat(20, 32'hE0);
        step();
        bus.in_valid = 0;
        chk("ar_pc20", bus.out_pc, 20);
        step();
        chk("ar_end", bus.out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
